// File: rtl/imem_loader.sv
// imem_loader: receives a framed, checksummed byte stream and writes the payload into instruction memory
module imem_loader #(
  parameter int unsigned SIZE      = 64,
  parameter logic [63:0] BASE_ADDR = 64'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        wr_en,
  output logic [63:0] wr_addr,
  output logic [7:0]  wr_data,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [1:0]  err_code,
  output logic [15:0] bytes_written
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_LO,
    S_LEN_HI,
    S_DATA,
    S_CHECK,
    S_DONE,
    S_ERROR
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic        r_in_ready;
  logic        r_wr_en;
  logic [63:0] r_wr_addr;
  logic [7:0]  r_wr_data;
  logic        r_busy;
  logic        r_done;
  logic        r_error;
  logic [1:0]  r_err_code;
  logic [15:0] r_bytes;
  logic [7:0]  r_len_lo;
  logic [15:0] r_len;
  logic [15:0] r_count;
  logic [7:0]  r_csum;
  logic        w_xfer;
  logic        w_start;
  logic        w_active;
  logic [15:0] w_n;
  logic        w_too_long;

  assign w_xfer     = in_valid & r_in_ready;
  assign w_start    = start & (r_state inside {S_IDLE, S_DONE, S_ERROR});
  assign w_n        = {in_data, r_len_lo};
  assign w_too_long = 32'(w_n) > SIZE;
  assign w_active   = w_next inside {S_LEN_LO, S_LEN_HI, S_DATA, S_CHECK};

  // state register; reset aborts any load in progress immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // frame sequencing: length bytes, payload, trailer, then a sticky result state
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE, S_ERROR: w_next = start ? S_LEN_LO : r_state;
      S_LEN_LO: w_next = w_xfer ? S_LEN_HI : S_LEN_LO;
      S_LEN_HI: w_next = !w_xfer ? S_LEN_HI : w_too_long ? S_ERROR : (w_n == 16'd0) ? S_CHECK : S_DATA;
      S_DATA:   w_next = (w_xfer && (r_count + 16'd1 == r_len)) ? S_CHECK : S_DATA;
      S_CHECK:  w_next = !w_xfer ? S_CHECK : (in_data == r_csum) ? S_DONE : S_ERROR;
      default:  w_next = S_IDLE;
    endcase
  end

  // registered handshake, status, length/checksum tracking and the one-cycle-delayed memory write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_in_ready <= 1'b0;
      r_wr_en    <= 1'b0;
      r_wr_addr  <= BASE_ADDR;
      r_wr_data  <= 8'h00;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
      r_err_code <= 2'b00;
      r_bytes    <= 16'd0;
      r_len_lo   <= 8'h00;
      r_len      <= 16'd0;
      r_count    <= 16'd0;
      r_csum     <= 8'h00;
    end else begin
      r_in_ready <= w_active;
      r_busy     <= w_active;
      r_done     <= w_next == S_DONE;
      r_error    <= w_next == S_ERROR;
      r_wr_en    <= 1'b0;
      if (w_start) begin
        r_err_code <= 2'b00;
        r_bytes    <= 16'd0;
        r_csum     <= 8'h00;
        r_count    <= 16'd0;
      end
      if (r_state == S_LEN_LO && w_xfer) r_len_lo <= in_data;
      if (r_state == S_LEN_HI && w_xfer) begin
        r_len <= w_n;
        if (w_too_long) r_err_code <= 2'b01;
      end
      if (r_state == S_DATA && w_xfer) begin
        r_wr_en   <= 1'b1;
        r_wr_data <= in_data;
        r_wr_addr <= BASE_ADDR + 64'(r_count);
        r_count   <= r_count + 16'd1;
        r_bytes   <= r_count + 16'd1;
        r_csum    <= r_csum ^ in_data;
      end
      if (r_state == S_CHECK && w_xfer && in_data != r_csum) r_err_code <= 2'b10;
    end
  end

  assign in_ready      = r_in_ready;
  assign wr_en         = r_wr_en;
  assign wr_addr       = r_wr_addr;
  assign wr_data       = r_wr_data;
  assign busy          = r_busy;
  assign done          = r_done;
  assign error         = r_error;
  assign err_code      = r_err_code;
  assign bytes_written = r_bytes;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: random framed loads against a frame-level model, with a scoreboard monitor on the write port and status
module tb_imem_loader;
  localparam int SIZE = 64;
  localparam logic [63:0] BASE = 64'd0;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        wr_en;
  logic [63:0] wr_addr;
  logic [7:0]  wr_data;
  logic        busy;
  logic        done;
  logic        error;
  logic [1:0]  err_code;
  logic [15:0] bytes_written;

  imem_loader #(.SIZE(SIZE), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .error(error), .err_code(err_code), .bytes_written(bytes_written)
  );

  typedef struct { logic [63:0] addr; logic [7:0] data; int cyc; int bw; } wr_t;
  typedef struct { logic dn; logic er; logic [1:0] code; int bw; } res_t;

  wr_t        wq[$];
  res_t       rq[$];
  logic [7:0] pay[$];
  int         tests = 0;
  int         fails = 0;
  int         cyc = 0;
  logic       prev_de = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // scoreboard monitor: every write and every frame result is matched against the model's queues
  always @(negedge clk) begin
    wr_t  w;
    res_t r;
    if (wr_en) begin
      if (wq.size() == 0) check("unexpected_write", 1, 0);
      else begin
        w = wq.pop_front();
        check("wr_addr", wr_addr, w.addr);
        check("wr_data", 64'(wr_data), 64'(w.data));
        check("wr_latency", 64'(cyc), 64'(w.cyc));
        check("bytes_written_inc", 64'(bytes_written), 64'(w.bw));
      end
    end
    if ((done | error) && !prev_de) begin
      if (rq.size() == 0) check("unexpected_result", 1, 0);
      else begin
        r = rq.pop_front();
        check("done", 64'(done), 64'(r.dn));
        check("error", 64'(error), 64'(r.er));
        check("err_code", 64'(err_code), 64'(r.code));
        check("bytes_written_end", 64'(bytes_written), 64'(r.bw));
        check("busy_end", 64'(busy), 0);
      end
    end
    if (done && error) check("done_and_error", 1, 0);
    prev_de = done | error;
  end

  // drive one byte from a negedge until it is accepted; returns at the negedge after the transfer edge
  task automatic send(input logic [7:0] b, input bit is_pay, input int idx);
    int g;
    wr_t w;
    in_valid = 1'b1;
    in_data  = b;
    g = 0;
    while (!in_ready && g < 50) begin
      @(negedge clk);
      g++;
    end
    if (!in_ready) check("in_ready_timeout", 0, 1);
    else if (is_pay) begin
      w.addr = BASE + 64'(idx);
      w.data = b;
      w.cyc  = cyc + 1;
      w.bw   = idx + 1;
      wq.push_back(w);
    end
    @(negedge clk);
  endtask

  task automatic drain();
    int g;
    g = 0;
    while ((wq.size() != 0 || rq.size() != 0) && g < 100) begin
      @(negedge clk);
      g++;
    end
    check("drain_pending", 64'(wq.size() + rq.size()), 0);
  endtask

  // one frame: length field n, payload in pay, given trailer; start pulsed again at payload index busy_at
  task automatic frame(input int n, input logic [7:0] trailer, input int maxgap, input int busy_at);
    logic [7:0] x;
    res_t r;
    x = 8'h00;
    foreach (pay[i]) x ^= pay[i];
    if (n > SIZE)          r = '{dn: 1'b0, er: 1'b1, code: 2'b01, bw: 0};
    else if (trailer == x) r = '{dn: 1'b1, er: 1'b0, code: 2'b00, bw: n};
    else                   r = '{dn: 1'b0, er: 1'b1, code: 2'b10, bw: n};
    rq.push_back(r);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    send(8'(n), 0, 0);
    send(8'(n >> 8), 0, 0);
    if (n > SIZE) begin
      in_valid = 1'b0;
      check("ready_after_overflow", 64'(in_ready), 0);
      repeat (3) @(negedge clk);
      check("ready_still_low", 64'(in_ready), 0);
    end else begin
      for (int i = 0; i < n; i++) begin
        in_valid = 1'b0;
        repeat ($urandom_range(0, maxgap)) @(negedge clk);
        start = (i == busy_at);
        send(pay[i], 1, i);
        start = 1'b0;
      end
      send(trailer, 0, 0);
      in_valid = 1'b0;
    end
    drain();
  endtask

  task automatic rand_pay(input int n);
    pay.delete();
    for (int i = 0; i < n; i++) pay.push_back(8'($urandom));
  endtask

  function automatic logic [7:0] xsum();
    logic [7:0] x;
    x = 8'h00;
    foreach (pay[i]) x ^= pay[i];
    return x;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] prog [16] = '{8'hB3, 8'h00, 8'h21, 8'h00, 8'h23, 8'h26, 8'h10, 8'h00,
                              8'h83, 8'h21, 8'hC0, 8'h00, 8'hE3, 8'h0A, 8'h31, 8'hFE};
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    repeat (2) @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 0);
    check("rst_wr_en", 64'(wr_en), 0);
    check("rst_busy", 64'(busy), 0);
    check("rst_done", 64'(done), 0);
    check("rst_error", 64'(error), 0);
    check("rst_err_code", 64'(err_code), 0);
    check("rst_wr_addr", wr_addr, BASE);
    check("rst_wr_data", 64'(wr_data), 0);
    check("rst_bytes_written", 64'(bytes_written), 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_ignores_valid_busy", 64'(busy), 0);

    pay.delete();
    foreach (prog[i]) pay.push_back(prog[i]);
    frame(16, 8'hC3, 0, -1);
    check("prog_done", 64'(done), 1);
    frame(16, 8'hC2, 1, -1);
    check("prog_bad_err_code", 64'(err_code), 2'b10);
    pay.delete();
    frame(65, 8'h00, 0, -1);
    frame(0, 8'h00, 0, -1);
    check("empty_done", 64'(done), 1);
    frame(0, 8'h5A, 0, -1);
    check("empty_bad_code", 64'(err_code), 2'b10);
    rand_pay(SIZE);
    frame(SIZE, xsum(), 0, -1);
    rand_pay(SIZE);
    frame(SIZE, xsum(), 3, -1);

    rand_pay(16);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    send(8'd16, 0, 0);
    send(8'd0, 0, 0);
    for (int i = 0; i < 5; i++) send(pay[i], 1, i);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_busy", 64'(busy), 0);
    check("midrst_wr_en", 64'(wr_en), 0);
    check("midrst_in_ready", 64'(in_ready), 0);
    check("midrst_bytes_written", 64'(bytes_written), 0);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("midrst_no_write", 64'(wq.size()), 0);
    wq.delete();
    rand_pay(16);
    frame(16, xsum(), 2, 7);

    for (int k = 0; k < 24; k++) begin
      int n;
      logic [7:0] t;
      n = ($urandom_range(0, 5) == 0) ? SIZE + 1 + int'($urandom_range(0, 200)) : int'($urandom_range(0, SIZE));
      rand_pay(n > SIZE ? 0 : n);
      t = xsum();
      if ($urandom_range(0, 3) == 0) t ^= 8'($urandom_range(1, 255));
      frame(n, t, int'($urandom_range(0, 3)), ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 63)) : -1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
